// File: rtl/ss_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package ss_pkg;

  localparam int SS_NUM_DIGITS = 4;
  localparam int SS_DATA_W     = SS_NUM_DIGITS * 4;

  typedef logic [3:0]      ss_digit_t;
  typedef logic [3:0][3:0] ss_disp_t;

  typedef enum logic {
    IDLE,
    HOLD
  } ss_arb_state_t;

endpackage

// File: rtl/ss_display_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping modulo NUM_REQ.
module rr_picker
  import ss_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] win_o,
  output logic                       valid_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Extra bit on the sum lets the wrap work for non-power-of-two NUM_REQ.
  always_comb begin
    valid_o = 1'b0;
    win_o   = '0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      idx = sum[IW-1:0];
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        win_o   = idx;
      end
    end
  end

endmodule

// File: rtl/ss_display_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display; grants are held for
// HOLD_TICKS refresh ticks. Optional requester-0 preemption via SS_ARB_PREEMPT_EN.
module ss_display_arbiter
  import ss_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int HOLD_TICKS = 3
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   tick_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*16-1:0]  data_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [SS_DATA_W-1:0]   bin_o,
  output logic                   blank_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_TICKS + 1);

  if (HOLD_TICKS < 1 || NUM_REQ < 2 || NUM_REQ > 8) begin : gBadParam
    $error("ss_display_arbiter: HOLD_TICKS must be >= 1 and NUM_REQ in 2..8");
  end

  logic [SS_DATA_W-1:0] dataArr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
    assign dataArr[g] = data_i[g*16 +: 16];
  end

  ss_arb_state_t        state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        rrPtr_q, rrPtr_d;
  logic [CW-1:0]        holdCnt_q, holdCnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [SS_DATA_W-1:0] bin_q, bin_d;
  logic                 blank_q, blank_d;

  logic [IW-1:0] pickPtr;
  logic [IW-1:0] pickWin;
  logic          pickValid;
  logic [IW-1:0] nextOwner;
  logic          releaseEv;
  logic          expireEv;
  logic          preempt;
  logic          grantNew;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) uPicker (
    .req_i   (req_i),
    .ptr_i   (pickPtr),
    .win_o   (pickWin),
    .valid_o (pickValid)
  );

  assign nextOwner = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign releaseEv = !req_i[owner_q];
  assign expireEv  = tick_i && (holdCnt_q == CW'(HOLD_TICKS - 1));

`ifdef SS_ARB_PREEMPT_EN
  assign preempt = (state_q == HOLD) && (owner_q != '0) && req_i[0];
`else
  assign preempt = 1'b0;
`endif

  // The picker always sees the pointer that applies on this edge, so IDLE
  // arbitration and expiry/release re-arbitration share one instance.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rrPtr_d   = rrPtr_q;
    holdCnt_d = holdCnt_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    bin_d     = bin_q;
    blank_d   = blank_q;
    pickPtr   = rrPtr_q;
    grantNew  = 1'b0;

    case (state_q)
      IDLE: begin
        grantNew = pickValid;
      end
      HOLD: begin
        if (preempt) begin
          rrPtr_d   = owner_q;
          owner_d   = '0;
          holdCnt_d = '0;
          gnt_d     = NUM_REQ'(1);
          ack_d     = NUM_REQ'(1);
          bin_d     = dataArr[0];
        end else if (releaseEv || expireEv) begin
          rrPtr_d = nextOwner;
          pickPtr = nextOwner;
          if (pickValid) begin
            grantNew = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            blank_d = 1'b1;
          end
        end else begin
          bin_d = dataArr[owner_q];
          if (tick_i) begin
            holdCnt_d = holdCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grantNew) begin
      state_d   = HOLD;
      owner_d   = pickWin;
      holdCnt_d = '0;
      gnt_d     = NUM_REQ'(1) << pickWin;
      ack_d     = NUM_REQ'(1) << pickWin;
      bin_d     = dataArr[pickWin];
      blank_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rrPtr_q   <= '0;
      holdCnt_q <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      bin_q     <= '0;
      blank_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rrPtr_q   <= rrPtr_d;
      holdCnt_q <= holdCnt_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      bin_q     <= bin_d;
      blank_q   <= blank_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign ack_o   = ack_q;
  assign bin_o   = bin_q;
  assign blank_o = blank_q;

endmodule

// File: tb/tb_ss_display_arbiter.sv
// Self-checking bench for ss_display_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural ownership model.
module tb_ss_display_arbiter;

  localparam int N = 4;
  localparam int H = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [3:0]  req;
  logic [15:0] d [4];
  logic [63:0] dataFlat;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [15:0] bin;
  logic        blank;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: owner index (-1 = nobody), search pointer, ticks consumed.
  int          mOwner;
  int          mPtr;
  int          mTicks;
  logic [3:0]  eGnt;
  logic [3:0]  eAck;
  logic [15:0] eBin;
  logic        eBlank;

  wire [24:0] obs    = {gnt, ack, bin, blank};
  wire [24:0] expVec = {eGnt, eAck, eBin, eBlank};

  always #5 clk = ~clk;

  assign dataFlat = {d[3], d[2], d[1], d[0]};

  ss_display_arbiter #(
    .NUM_REQ    (N),
    .HOLD_TICKS (H)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_i  (tick),
    .req_i   (req),
    .data_i  (dataFlat),
    .gnt_o   (gnt),
    .ack_o   (ack),
    .bin_o   (bin),
    .blank_o (blank)
  );

  // Ownership rules: a grant lasts H ticks or until its request drops; the
  // next search starts just after the outgoing owner.
  task automatic modelEdge();
    int  start;
    bit  pick;
    bit  found;
    eAck = '0;
    if (reset) begin
      mOwner = -1; mPtr = 0; mTicks = 0;
      eGnt = '0; eBin = '0; eBlank = 1'b1;
      return;
    end
    pick  = 1'b0;
    start = mPtr;
    if (mOwner < 0) pick = 1'b1;
`ifdef SS_ARB_PREEMPT_EN
    else if (mOwner > 0 && req[0]) begin
      mPtr = mOwner; mOwner = 0; mTicks = 0;
      eGnt = 4'b0001; eAck = 4'b0001; eBin = d[0];
    end
`endif
    else if (!req[mOwner] || (tick && (mTicks + 1 == H))) begin
      mPtr  = (mOwner + 1) % N;
      start = mPtr;
      pick  = 1'b1;
    end else begin
      eBin = d[mOwner];
      if (tick) mTicks++;
    end
    if (pick) begin
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        int w;
        w = (start + j) % N;
        if (!found && req[w]) begin
          found  = 1'b1;
          mOwner = w; mTicks = 0;
          eGnt   = 4'(1 << w); eAck = 4'(1 << w);
          eBin   = d[w]; eBlank = 1'b0;
        end
      end
      if (!found) begin
        mOwner = -1; eGnt = '0; eBlank = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; tick = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      nTests++;
      if (obs !== 25'h1) begin
        nFail++;
        $display("[TB] FAIL reset_idle cyc %0d: got %h want %h", c, obs, 25'h1);
      end
    end
  endtask

  task automatic test_single();
    applyReset();
    tick = 1'b1; req = 4'b0010; d[1] = 16'h1234;
    step();
    nTests++;
    if (obs !== {4'b0010, 4'b0010, 16'h1234, 1'b0}) begin
      nFail++;
      $display("[TB] FAIL single_grant: got %h want %h", obs, {4'b0010, 4'b0010, 16'h1234, 1'b0});
    end
    d[1] = 16'hABCD;
    step();
    nTests++;
    if (obs !== {4'b0010, 4'b0000, 16'hABCD, 1'b0}) begin
      nFail++;
      $display("[TB] FAIL single_live_data: got %h want %h", obs, {4'b0010, 4'b0000, 16'hABCD, 1'b0});
    end
    step();
    step();
    nTests++;
    if (obs !== {4'b0010, 4'b0010, 16'hABCD, 1'b0}) begin
      nFail++;
      $display("[TB] FAIL single_regrant: got %h want %h", obs, {4'b0010, 4'b0010, 16'hABCD, 1'b0});
    end
  endtask

  task automatic test_rotation();
    logic [3:0] wantG;
    logic [3:0] wantA;
    applyReset();
    tick = 1'b1; req = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      step();
      wantG = 4'(1 << (((c - 1) / H) % N));
      wantA = (((c - 1) % H) == 0) ? wantG : 4'b0000;
      nTests++;
      if (gnt !== wantG || ack !== wantA || blank !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL rotation cyc %0d: gnt %b ack %b blank %b want gnt %b ack %b blank 0",
                 c, gnt, ack, blank, wantG, wantA);
      end
    end
  endtask

  task automatic test_release();
    applyReset();
    tick = 1'b1; req = 4'b0100;
    step(); step();
    req = 4'b1000;
    step();
    nTests++;
    if (gnt !== 4'b1000 || ack !== 4'b1000) begin
      nFail++;
      $display("[TB] FAIL release_handover: gnt %b ack %b want 1000 1000", gnt, ack);
    end
    applyReset();
    d[2] = 16'h5A5A; req = 4'b0100;
    step(); step();
    req = 4'b0000;
    step();
    nTests++;
    if (obs !== {4'b0000, 4'b0000, 16'h5A5A, 1'b1}) begin
      nFail++;
      $display("[TB] FAIL release_idle: got %h want %h", obs, {4'b0000, 4'b0000, 16'h5A5A, 1'b1});
    end
  endtask

  task automatic test_tick_low();
    int bad;
    applyReset();
    tick = 1'b0; req = 4'b1010;
    step();
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (gnt !== 4'b0010 || ack !== 4'b0000) bad++;
    end
    nTests++;
    if (bad != 0) begin
      nFail++;
      $display("[TB] FAIL tick_low_hold: %0d bad cycles, want 0 (last gnt %b)", bad, gnt);
    end
    tick = 1'b1;
    step(); step(); step();
    nTests++;
    if (gnt !== 4'b1000 || ack !== 4'b1000) begin
      nFail++;
      $display("[TB] FAIL tick_low_expire: gnt %b ack %b want 1000 1000", gnt, ack);
    end
  endtask

  task automatic test_reset_mid();
    applyReset();
    tick = 1'b1; req = 4'b1000;
    step(); step();
    reset = 1'b1;
    step();
    nTests++;
    if (obs !== 25'h1) begin
      nFail++;
      $display("[TB] FAIL reset_mid: got %h want %h", obs, 25'h1);
    end
    reset = 1'b0; req = 4'b1111;
    step();
    nTests++;
    if (gnt !== 4'b0001 || ack !== 4'b0001) begin
      nFail++;
      $display("[TB] FAIL reset_mid_regrant: gnt %b ack %b want 0001 0001", gnt, ack);
    end
  endtask

`ifdef SS_ARB_PREEMPT_EN
  task automatic test_preempt();
    applyReset();
    tick = 1'b1; req = 4'b0100;
    step();
    req = 4'b0101;
    step();
    nTests++;
    if (gnt !== 4'b0001 || ack !== 4'b0001) begin
      nFail++;
      $display("[TB] FAIL preempt_grab: gnt %b ack %b want 0001 0001", gnt, ack);
    end
    step(); step(); step();
    nTests++;
    if (gnt !== 4'b0100) begin
      nFail++;
      $display("[TB] FAIL preempt_resume: gnt %b want 0100", gnt);
    end
  endtask
`endif

  task automatic test_random();
    applyReset();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      tick  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) d[k] = 16'($urandom);
      step();
      nTests++;
      if (obs !== expVec) begin
        nFail++;
        $display("[TB] FAIL random cyc %0d: got %h want %h", c, obs, expVec);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1; req = '0;
    for (int k = 0; k < N; k++) d[k] = '0;
    mOwner = -1; mPtr = 0; mTicks = 0;
    eGnt = '0; eAck = '0; eBin = '0; eBlank = 1'b1;
    test_reset();
    test_single();
    test_rotation();
    test_release();
    test_tick_low();
    test_reset_mid();
`ifdef SS_ARB_PREEMPT_EN
    test_preempt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
